// File: rtl/multi_spinner.sv
// Button and mouse driven rotary spinners, one angle counter per channel.
// Optional mouse residue path: define SPINNER_MOUSE_EN.
module multi_spinner #(
    parameter int CHANNELS  = 2,
    parameter int ANGLE_W   = 4,
    parameter int ACC_HOLD  = 8,
    parameter int MOUSE_MAX = 2
) (
    input  logic                        clock_40,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [CHANNELS-1:0]         btn_left,
    input  logic [CHANNELS-1:0]         btn_right,
    input  logic [CHANNELS-1:0]         btn_acc,
    input  logic [CHANNELS*9-1:0]       delta_in,
    input  logic [CHANNELS-1:0]         delta_strobe,
    output logic [CHANNELS*ANGLE_W-1:0] spin_angle,
    output logic [CHANNELS-1:0]         spin_dir,
    output logic [CHANNELS-1:0]         spin_moved
);

    localparam int HW = $clog2(ACC_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(ACC_HOLD);

    typedef enum logic [1:0] {IDLE, SPIN_CW, SPIN_CCW} state_t;

    logic r_tick_prev;
    logic w_edge;

    // Reloading from tick during reset suppresses a false edge afterwards.
    always_ff @(posedge clock_40) begin
        r_tick_prev <= tick;
    end

    assign w_edge = tick & ~r_tick_prev;

`ifndef SPINNER_MOUSE_EN
    logic w_unused;
    assign w_unused = ^{delta_in, delta_strobe};
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t              r_state;
        state_t              w_next;
        logic [HW-1:0]       r_hold;
        logic [ANGLE_W-1:0]  r_angle;
        logic                r_dir;
        logic                r_moved;
        logic                w_fast;
        logic [2:0]          w_step;
        logic signed [12:0]  w_take;
        logic signed [12:0]  w_net;

        always_comb begin
            w_next = IDLE;
            if (btn_right[g] && !btn_left[g]) begin
                w_next = SPIN_CW;
            end else if (btn_left[g] && !btn_right[g]) begin
                w_next = SPIN_CCW;
            end
        end

        always_comb begin
            w_fast = (w_next == r_state) && (r_hold >= HOLD_MAX);
            w_step = btn_acc[g] ? 3'd2 : 3'd1;
            if (w_fast) begin
                w_step = w_step << 1;
            end
            w_net = w_take;
            if (w_next == SPIN_CW) begin
                w_net = w_take + $signed({10'd0, w_step});
            end else if (w_next == SPIN_CCW) begin
                w_net = w_take - $signed({10'd0, w_step});
            end
        end

`ifdef SPINNER_MOUSE_EN
        localparam logic signed [12:0] MMAX = 13'(MOUSE_MAX);
        logic signed [11:0] r_res;
        logic signed [12:0] w_sum;
        logic signed [12:0] w_sat;
        logic        [8:0]  w_d;

        assign w_d = delta_in[g*9 +: 9];

        always_comb begin
            w_sum = {r_res[11], r_res};
            if (delta_strobe[g]) begin
                w_sum = {r_res[11], r_res} + {{4{w_d[8]}}, w_d};
            end
            w_sat = w_sum;
            if (w_sum > 13'sd2047) begin
                w_sat = 13'sd2047;
            end else if (w_sum < -13'sd2048) begin
                w_sat = -13'sd2048;
            end
            w_take = w_sat;
            if (w_sat > MMAX) begin
                w_take = MMAX;
            end else if (w_sat < -MMAX) begin
                w_take = -MMAX;
            end
        end

        always_ff @(posedge clock_40) begin
            if (reset) begin
                r_res <= '0;
            end else if (w_edge) begin
                r_res <= 12'(w_sat - w_take);
            end else begin
                r_res <= w_sat[11:0];
            end
        end
`else
        assign w_take = '0;
`endif

        always_ff @(posedge clock_40) begin
            if (reset) begin
                r_state <= IDLE;
            end else if (w_edge) begin
                r_state <= w_next;
            end
        end

        always_ff @(posedge clock_40) begin
            if (reset) begin
                r_hold  <= '0;
                r_angle <= '0;
                r_dir   <= 1'b0;
                r_moved <= 1'b0;
            end else begin
                r_moved <= 1'b0;
                if (w_edge) begin
                    if (w_next != r_state) begin
                        r_hold <= '0;
                    end else if (w_next != IDLE && r_hold < HOLD_MAX) begin
                        r_hold <= r_hold + 1'b1;
                    end
                    r_angle <= r_angle + w_net[ANGLE_W-1:0];
                    if (w_net != 13'sd0) begin
                        r_dir <= w_net[12];
                    end
                    r_moved <= |w_net[ANGLE_W-1:0];
                end
            end
        end

        assign spin_angle[g*ANGLE_W +: ANGLE_W] = r_angle;
        assign spin_dir[g]   = r_dir;
        assign spin_moved[g] = r_moved;
    end

endmodule
